des_uart_tx: RTL
================

# des_uart_tx

Ciphertext serializer downstream of the DES core. It accepts 64-bit ciphertext words over a valid/ready handshake and buffers one word while another is on the line. Each word goes out as eight 8N1 UART frames on a single `tx` pin, most-significant byte first. It closes the serial-communication path of the pipelined DES design, taking what the DES stage produces and driving the board's UART TX.

## Interface
- `CLKS_PER_BIT`, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535
- `CNT_WIDTH`, default 16, width of `words_sent`
- `clk`  input  1  system clock, same domain as the DES core clock
- `reset`  input  1  reset, **synchronous, active-high**
- `ct_data`  input  64  ciphertext word
- `ct_valid`  input  1  `ct_data` valid
- `ct_ready`  output  1  block can accept a word this cycle
- `tx`  output  1  UART serial output, idle high
- `busy`  output  1  a word is held or being transmitted
- `word_done`  output  1  one-cycle pulse when the last stop bit of a word completes
- `words_sent`  output  CNT_WIDTH  count of fully transmitted words, wraps

## Operation
- **Holding register:** one 64-bit register plus `hold_valid`.
  - `ct_ready` = !`hold_valid` && !`reset`.
  - Handshake = `ct_valid` && `ct_ready` at a rising edge. It loads `ct_data` and sets `hold_valid`.
  - With `ct_ready` low, `ct_data`/`ct_valid` are ignored. The source must hold them.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If `hold_valid`, copy the holding register into the 64-bit shift register, clear `hold_valid`, byte_idx←0, and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx←0.
  - DATA: `tx` = current byte bit bit_idx, LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx<7: byte_idx++, shift register left by 8, go to START with no gap;
    - else: pulse `word_done`, `words_sent`++, go to IDLE.
- **Byte order:** current byte is shift[63:56]. Byte 0 = `ct_data`[63:56], byte 7 = `ct_data`[7:0].
- **Baud counter:** counts 0..CLKS_PER_BIT-1, restarts on every bit boundary and on every state entry.
- **Simultaneous events:**
  - A handshake may occur on the same edge the FSM (in IDLE) empties the holding register only if `hold_valid` was already 0. That case cannot arise, since `ct_ready` is low while `hold_valid`=1.
  - A handshake during any transmit state fills the holding register with no effect on the frame in progress.
- `busy` = (state != IDLE) || `hold_valid`. It is registered-equivalent, with no combinational path from `ct_valid`.
- `words_sent` wraps from 2^CNT_WIDTH-1 to 0.
- **Reset** (sync, any state, including mid-frame): state IDLE, `hold_valid`=0, counters 0, shift register 0. The frame is abandoned and `tx` returns to 1 on the edge reset is sampled. There is no partial-frame completion.
- **Reset values:** `tx`=1, `ct_ready`=0 while `reset` is high and 1 on the first cycle after, `busy`=0, `word_done`=0, `words_sent`=0.

## Timing
- `tx` is registered, with no glitches.
- Handshake at edge N: `hold_valid`=1 after N. The FSM loads at edge N+1 and `tx` falls after N+1 (2-cycle start latency from idle).
- `ct_ready` returns high after edge N+1, so a second word can be accepted at edge N+1 or later while word 1 transmits.
- Word duration: 80×CLKS_PER_BIT cycles from `tx` falling to STOP end.
- Back-to-back words: after the last STOP, one IDLE cycle with `tx`=1, then START of the held word. The inter-word gap is exactly CLKS_PER_BIT+1 high cycles counting the stop bit.
- `word_done` is asserted for exactly the one cycle in which the FSM enters IDLE. `words_sent` updates on the same edge.
- Throughput is limited by the UART only. The source never sees more than one word of backpressure slack.

## Test plan
1. **Single word.** Reset 3 cycles, CLKS_PER_BIT=4, send 64'h85E813540F0AB405.
   - `tx` falls 2 cycles after the handshake.
   - First byte bits = 0,1,0,1,0,0,0,0,1,1 (start, 0x85 LSB-first, stop).
   - Bytes decode 85 E8 13 54 0F 0A B4 05.
   - `word_done` pulses once, 320 cycles after `tx` fell, and `words_sent`=1.
2. **Back-to-back.** Present 64'h0123456789ABCDEF then 64'hFFFFFFFF00000000 with `ct_valid` held.
   - Second handshake occurs 1 cycle after the first load.
   - `ct_ready`=0 until word 1 ends.
   - Exactly a 5-cycle high gap between words (CLKS_PER_BIT=4); `words_sent`=2.
3. **Backpressure.** With a word held and another transmitting, hold `ct_valid`=1 with changing `ct_data` for 100 cycles.
   - No handshake occurs and the held word is unchanged.
4. **Reset mid-frame.** Assert `reset` during DATA bit 3 of byte 2.
   - `tx`=1, `busy`=0, `ct_ready`=0 the next cycle; `ct_ready`=1 after release.
   - `words_sent`=0; a new word then transmits correctly.
5. **Counter wrap.** Set CNT_WIDTH=2 and send 5 words. `words_sent` sequence is 1,2,3,0,1.
6. **Minimum baud.** CLKS_PER_BIT=2, word 64'hAA55AA55AA55AA55. Every bit lasts exactly 2 cycles and the word lasts 160 cycles.

Source files
------------

// File: rtl/des_uart_tx.sv
// Ciphertext serializer: buffers one 64-bit DES output word and sends it as
// eight 8N1 UART frames, most-significant byte first, LSB-first within a byte.
module des_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          ct_data,
  input  logic                 ct_valid,
  output logic                 ct_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 word_done,
  output logic [CNT_WIDTH-1:0] words_sent
);

  localparam logic [15:0] BitEnd = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                state_q, state_d;
  logic [63:0]           hold_q;
  logic                  hold_valid_q;
  logic [63:0]           shift_q, shift_d;
  logic [15:0]           baud_q, baud_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [2:0]            byte_idx_q, byte_idx_d;
  logic                  tx_q, tx_d;
  logic                  word_done_q, word_done_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;
  logic [7:0]            cur_byte;
  logic                  accept;
  logic                  take;
  logic                  bit_end;

  assign ct_ready   = !hold_valid_q && !reset;
  assign accept     = ct_valid && ct_ready;
  assign bit_end    = (baud_q == BitEnd);
  assign tx         = tx_q;
  assign busy       = (state_q != StIdle) || hold_valid_q;
  assign word_done  = word_done_q;
  assign words_sent = words_q;

  // Next-state logic; tx is derived from next-state values so the pin is a flop output.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    baud_d      = baud_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    word_done_d = 1'b0;
    words_d     = words_q;
    take        = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (hold_valid_q) begin
          take       = 1'b1;
          shift_d    = hold_q;
          byte_idx_d = 3'd0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_d = '0;
          if (byte_idx_q != 3'd7) begin
            byte_idx_d = byte_idx_q + 3'd1;
            shift_d    = {shift_q[55:0], 8'h00};
            state_d    = StStart;
          end else begin
            word_done_d = 1'b1;
            words_d     = words_q + CNT_WIDTH'(1);
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    cur_byte = shift_d[63:56];
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // State, holding register and output flops; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      byte_idx_q   <= '0;
      tx_q         <= 1'b1;
      word_done_q  <= 1'b0;
      words_q      <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      tx_q        <= tx_d;
      word_done_q <= word_done_d;
      words_q     <= words_d;
      // accept and take are mutually exclusive: ct_ready is low while a word is held
      if (accept) begin
        hold_q       <= ct_data;
        hold_valid_q <= 1'b1;
      end else if (take) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

endmodule
